// File: rtl/sw_port_pkt.sv
// sw_port_pkt -- switch output-port packet buffer.
//
// Accepts packets presented on port_data while sw_en is high. The first word
// of each packet is a destination header. A packet addressed to port_addr or
// to BCAST_ADDR is stored in a circular buffer. All other packets are ignored.
// A stored packet becomes visible to the reader only once its final word has
// arrived, at which point it is committed. A packet that overflows the buffer,
// or that is longer than MAX_PKT words, is rolled back and reported on
// drop_pulse.
//
// Ports:
//   clk, rst_n     single rising-edge clock, asynchronous active-low reset
//   sw_en          packet framing strobe (high for the whole packet)
//   port_data      packet word; the first word is the destination header
//   port_addr      this port's address (quasi-static)
//   rd_out         at least MAX_PKT free words are available
//   port_rd        pop the head word (ignored while port_rdy is low)
//   port_out       head word, first-word fall-through; 0 when port_rdy is low
//   port_eop       head word is the last word of its packet
//   port_rdy       at least one committed packet is buffered
//   drop_pulse     one-cycle pulse when a packet is discarded for overflow
//
// Optional feature (macro PORT_STATS_EN):
//   pkt_cnt, drop_cnt  16-bit saturating counts of commits and drops
module sw_port_pkt #(
  parameter int                 W_WIDTH    = 8,
  parameter int                 FIFO_SIZE  = 64,
  parameter int                 MAX_PKT    = 16,
  parameter logic [W_WIDTH-1:0] BCAST_ADDR = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sw_en,
  input  logic [W_WIDTH-1:0] port_data,
  input  logic [W_WIDTH-1:0] port_addr,
  output logic               rd_out,
  input  logic               port_rd,
  output logic [W_WIDTH-1:0] port_out,
  output logic               port_eop,
  output logic               port_rdy,
  output logic               drop_pulse
`ifdef PORT_STATS_EN
  ,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FS_P  = PW'(FIFO_SIZE);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PKT);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCEPT  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Pointers carry one extra MSB so that a full buffer can be told apart
  // from an empty one.
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] cm_ptr_reg, cm_ptr_next;   // end of the last committed packet
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] pkt_num_reg, pkt_num_next; // committed packets buffered
  logic [PW-1:0] len_reg, len_next;         // words written for the current packet
  logic          sw_en_d_reg;
  logic          drop_reg;

  logic [W_WIDTH-1:0] mem [FIFO_SIZE];
  logic [FIFO_SIZE-1:0] eop_reg;

  logic [PW-1:0] used_words;
  logic [PW-1:0] free_words;
  logic          full;
  logic          hdr_hit;
  logic          pop;
  logic          head_eop;
  logic          wr_en;
  logic          commit;
  logic          drop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx   = wr_ptr_reg[AW-1:0];
  assign last_idx = wr_idx - AW'(1);
  assign rd_idx   = rd_ptr_reg[AW-1:0];

  // Occupancy is measured from the read pointer, so words that have been
  // written but not yet committed still count against free space.
  assign used_words = wr_ptr_reg - rd_ptr_reg;
  assign free_words = FS_P - used_words;
  assign full       = (used_words == FS_P);
  assign rd_out     = (free_words >= MAX_P);

  assign hdr_hit  = (port_data == port_addr) || (port_data == BCAST_ADDR);
  assign port_rdy = (pkt_num_reg != '0);
  assign pop      = port_rd && port_rdy;
  assign head_eop = eop_reg[rd_idx];

  assign port_out   = port_rdy ? mem[rd_idx] : '0;
  assign port_eop   = port_rdy && head_eop;
  assign drop_pulse = drop_reg;

  // The header is recognised only on the rising edge of sw_en. This stops a
  // packet that was already in flight when reset was released from being
  // mistaken for a new header.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sw_en) begin
          if (!sw_en_d_reg && hdr_hit) begin
            if (full) begin
              drop       = 1'b1;
              state_next = DISCARD;
            end else begin
              wr_en      = 1'b1;
              len_next   = ONE_P;
              state_next = ACCEPT;
            end
          end else begin
            state_next = DISCARD;
          end
        end
      end
      ACCEPT: begin
        if (!sw_en) begin
          commit     = 1'b1;
          state_next = IDLE;
        end else if (full || (len_reg == MAX_P)) begin
          drop       = 1'b1;
          state_next = DISCARD;
        end else begin
          wr_en    = 1'b1;
          len_next = len_reg + ONE_P;
        end
      end
      DISCARD: begin
        if (!sw_en) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (drop) begin
      wr_ptr_next = cm_ptr_reg;
    end else if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + ONE_P;
    end

    cm_ptr_next = commit ? wr_ptr_reg : cm_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + ONE_P : rd_ptr_reg;

    // If a commit and an end-of-packet pop happen in the same cycle, the
    // two updates cancel and the count stays the same.
    pkt_num_next = pkt_num_reg;
    if (commit && !(pop && head_eop)) begin
      pkt_num_next = pkt_num_reg + ONE_P;
    end else if (!commit && pop && head_eop) begin
      pkt_num_next = pkt_num_reg - ONE_P;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      cm_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      pkt_num_reg <= '0;
      len_reg     <= '0;
      sw_en_d_reg <= 1'b1;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wr_ptr_reg  <= wr_ptr_next;
      cm_ptr_reg  <= cm_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      pkt_num_reg <= pkt_num_next;
      len_reg     <= len_next;
      sw_en_d_reg <= sw_en;
      drop_reg    <= drop;
    end
  end

  // Data storage is never reset. Stale contents are unreachable because the
  // pointers are cleared and the outputs are gated by port_rdy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= port_data;
    end
  end

  // EOP flags are held apart from the data so that the last word of a packet
  // can be marked retroactively at commit time. A commit never coincides with
  // a write, so the two updates never target the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eop_reg <= '0;
    end else begin
      if (wr_en) begin
        eop_reg[wr_idx] <= 1'b0;
      end
      if (commit) begin
        eop_reg[last_idx] <= 1'b1;
      end
    end
  end

`ifdef PORT_STATS_EN
  logic [15:0] pkt_cnt_reg;
  logic [15:0] drop_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (commit && (pkt_cnt_reg != 16'hFFFF)) begin
        pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
      end
      if (drop && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign pkt_cnt  = pkt_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_sw_port_pkt.sv
module tb_sw_port_pkt;

  localparam int W    = 8;
  localparam int FS   = 8;
  localparam int MAXP = 6;
  localparam logic [7:0] BCAST = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_en = 1'b0;
  logic [7:0] port_data = '0;
  logic [7:0] port_addr = 8'h05;
  logic       port_rd = 1'b0;
  logic       rd_out;
  logic [7:0] port_out;
  logic       port_eop;
  logic       port_rdy;
  logic       drop_pulse;

  sw_port_pkt #(
    .W_WIDTH   (W),
    .FIFO_SIZE (FS),
    .MAX_PKT   (MAXP),
    .BCAST_ADDR(BCAST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_en     (sw_en),
    .port_data (port_data),
    .port_addr (port_addr),
    .rd_out    (rd_out),
    .port_rd   (port_rd),
    .port_out  (port_out),
    .port_eop  (port_eop),
    .port_rdy  (port_rdy),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected state of the outputs for one cycle, as seen by the monitor.
  typedef struct {
    bit rdy;
    bit rdo;
    bit drop;
    bit pop;
  } rec_t;

  rec_t       recs[$];
  logic [8:0] exp_words[$];   // {eop, data}, in the order they must be read

  // Behavioural reference: the committed contents, the packet being
  // received, and the receive mode (0 idle, 1 accepting, 2 discarding).
  logic [8:0] m_buf[$];
  logic [7:0] m_pend[$];
  int         m_mode;
  bit         m_prev;
  int         m_npkt;
  bit         m_drop;
  int         rd_pct = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_buf.delete();
    m_pend.delete();
    exp_words.delete();
    m_mode = 0;
    m_prev = 1'b1;
    m_npkt = 0;
    m_drop = 1'b0;
  endfunction

  function automatic void model_step(bit sw, logic [7:0] d, bit rd);
    int         used;
    bit         full;
    bit         pop;
    logic [8:0] e;
    used   = m_buf.size() + m_pend.size();
    full   = (used >= FS);
    pop    = rd && (m_npkt > 0);
    m_drop = 1'b0;
    if (pop) begin
      e = m_buf.pop_front();
      if (e[8]) m_npkt--;
    end
    case (m_mode)
      0: if (sw) begin
        if (!m_prev && (d == port_addr || d == BCAST)) begin
          if (full) begin
            m_drop = 1'b1;
            m_mode = 2;
          end else begin
            m_pend.push_back(d);
            m_mode = 1;
          end
        end else begin
          m_mode = 2;
        end
      end
      1: if (!sw) begin
        for (int i = 0; i < m_pend.size(); i++) begin
          e = {(i == m_pend.size() - 1) ? 1'b1 : 1'b0, m_pend[i]};
          m_buf.push_back(e);
          exp_words.push_back(e);
        end
        m_npkt++;
        m_pend.delete();
        m_mode = 0;
      end else if (full || m_pend.size() >= MAXP) begin
        m_drop = 1'b1;
        m_pend.delete();
        m_mode = 2;
      end else begin
        m_pend.push_back(d);
      end
      default: if (!sw) m_mode = 0;
    endcase
    m_prev = sw;
  endfunction

  function automatic rec_t cur_rec(bit pop);
    rec_t r;
    r.rdy  = (m_npkt > 0);
    r.rdo  = ((FS - (m_buf.size() + m_pend.size())) >= MAXP);
    r.drop = m_drop;
    r.pop  = pop;
    return r;
  endfunction

  // One clock of stimulus: apply inputs just after the edge, record what the
  // outputs must show this cycle, then advance the model across the next edge.
  task automatic tick(input bit sw, input logic [7:0] d);
    bit rd;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rd        = ($urandom_range(99) < rd_pct);
    sw_en     = sw;
    port_data = d;
    port_rd   = rd;
    recs.push_back(cur_rec(rd && (m_npkt > 0)));
    model_step(sw, d, rd);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    port_rd = 1'b0;
    model_reset();
    recs.push_back(cur_rec(1'b0));
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'($urandom));
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len, input logic [7:0] base);
    tick(1'b1, hdr);
    for (int i = 1; i < len; i++) tick(1'b1, base + 8'(i));
    tick(1'b0, 8'h00);
  endtask

  // Monitor: checks every cycle's outputs against the queued expectations.
  initial begin
    rec_t       r;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (recs.size() != 0) begin
        r = recs.pop_front();
        chk("port_rdy", 32'(port_rdy), 32'(r.rdy));
        chk("rd_out", 32'(rd_out), 32'(r.rdo));
        chk("drop_pulse", 32'(drop_pulse), 32'(r.drop));
        if (r.rdy) begin
          if (exp_words.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head_word actual=%0h expected=none at %0t", port_out, $time);
          end else begin
            e = exp_words[0];
            chk("port_out", 32'(port_out), 32'(e[7:0]));
            chk("port_eop", 32'(port_eop), 32'(e[8]));
            if (r.pop) void'(exp_words.pop_front());
          end
        end else begin
          chk("port_out_idle", 32'(port_out), 32'h0);
          chk("port_eop_idle", 32'(port_eop), 32'h0);
        end
      end
    end
  end

  initial begin
    int r;
    model_reset();
    do_reset();
    idle(2);

    // Matching packet, read back after it has been committed.
    rd_pct = 0;
    send_pkt(8'h05, 4, 8'hA0);
    idle(2);
    rd_pct = 100;
    idle(6);

    // Packet for another port is ignored.
    rd_pct = 0;
    send_pkt(8'h07, 4, 8'h10);
    idle(2);

    // Broadcast header is accepted.
    send_pkt(8'hFF, 2, 8'h20);
    idle(1);
    rd_pct = 100;
    idle(4);

    // Overflow: a committed 6-word packet leaves no room for a 4-word one.
    rd_pct = 0;
    send_pkt(8'h05, 6, 8'h30);
    send_pkt(8'h05, 4, 8'h40);
    idle(2);
    rd_pct = 50;
    idle(12);

    // Over-length packet is dropped.
    rd_pct = 0;
    send_pkt(8'h05, 8, 8'h50);
    idle(2);

    // Reset in the middle of a packet, then a normal packet afterwards.
    send_pkt(8'h05, 2, 8'h60);
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h71);
    do_reset();
    tick(1'b1, 8'h72);
    tick(1'b1, 8'h73);
    idle(1);
    send_pkt(8'h05, 3, 8'h80);
    rd_pct = 100;
    idle(5);

    // Randomised traffic.
    for (int p = 0; p < 150; p++) begin
      r = $urandom_range(3);
      case ($urandom_range(3))
        0: rd_pct = 0;
        1: rd_pct = 30;
        2: rd_pct = 70;
        default: rd_pct = 100;
      endcase
      send_pkt((r < 2) ? 8'h05 : (r == 2) ? BCAST : 8'($urandom),
               $urandom_range(1, 8), 8'($urandom));
      idle($urandom_range(0, 2));
    end
    rd_pct = 100;
    idle(40);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
